rgmii_rx_ctrl: RTL and testbench
================================

Name: rgmii_rx_ctrl

Overview:
- Receive-side sequencer behind the source-synchronous DDR input capture of the RGMII receive path.
- Consumes the per-cycle rising/falling-edge samples of {RX_CTL, RXD[3:0]} and assembles GMII-style bytes at 10/100/1000 Mb/s.
- Decodes RGMII in-band link status during inter-frame gaps.
- Keeps saturating frame and error counters for the MAC and CSR logic. Runs entirely in the recovered RX clock domain.

Parameters:
- CNT_WIDTH, 16, width of the frame and error counters.
- INBAND_EN, 1, 1 enables in-band status decode; 0 holds the status outputs at reset values.

Ports:
- clk  in  1  RX clock, the buffered clock from the DDR input stage
- rst_n  in  1  asynchronous active-low reset
- speed_i  in  2  00=10M, 01=100M, 10=1000M; 11 is treated as 1000M
- cnt_clr_i  in  1  synchronous clear of both counters
- ddr_q1_i  in  5  rising-edge sample {rx_ctl, rxd[3:0]}
- ddr_q2_i  in  5  falling-edge sample {rx_ctl, rxd[3:0]}
- rx_data_o  out  8  assembled byte
- rx_valid_o  out  1  byte strobe, one cycle per byte
- rx_dv_o  out  1  frame-active level
- rx_er_o  out  1  error flag, qualified by rx_valid_o
- link_up_o  out  1  in-band link status
- link_speed_o  out  2  in-band speed, 00/01/10
- full_duplex_o  out  1  in-band duplex
- frame_cnt_o  out  CNT_WIDTH  completed frames
- err_cnt_o  out  CNT_WIDTH  frames containing at least one error

Behaviour:
- Decode: dv = q1[4]; er = q1[4] XOR q2[4].
- Reset, asynchronous on rst_n low: all outputs 0; FSM enters WAIT_IDLE.
- All outputs are registered.
- FSM states: WAIT_IDLE, IDLE, FRAME, NIB_LO, NIB_HI.
  - WAIT_IDLE: stay while dv=1, so no partial frame is delivered after a mid-frame reset; go to IDLE when dv=0.
  - IDLE: latch speed_i into the internal mode. On dv=1:
    - mode 1000: go to FRAME and emit the first byte.
    - mode 10/100: capture q1[3:0] as the low nibble and go to NIB_HI.
  - FRAME (1000): each cycle with dv=1, rx_data={q2[3:0],q1[3:0]}, rx_valid=1, rx_er=er. When dv=0, return to IDLE.
  - NIB_HI (10/100): if dv=1, emit byte {q1[3:0], low nibble} with rx_valid=1 and rx_er = er OR the er of the low-nibble cycle, then go to NIB_LO.
    - If dv=0 here (odd nibble count): emit {4'h0, low nibble} with rx_er=1, count the frame as errored, go to IDLE.
  - NIB_LO: if dv=1, capture the low nibble and go to NIB_HI. If dv=0, go to IDLE.
- In 10/100 mode only q1 is used; q2 data is ignored except for er.
- Latency: 1 clk from the completing sample to rx_valid_o.
- rx_dv_o is high from the first rx_valid_o through the cycle after the last byte.
- speed_i is sampled only in IDLE; changes mid-frame take effect at the next frame.
- Frame end (dv falling while in FRAME/NIB_LO/NIB_HI): frame_cnt increments; err_cnt increments if any er was seen in the frame. Both counters saturate at all-ones.
- cnt_clr_i has priority over a same-cycle increment; the result is 0.
- In-band status, when INBAND_EN=1: in IDLE with dv=0 and er=0, sample q1[3:0] as {duplex, speed[1:0], link}.
  - Outputs update only after 2 consecutive identical samples.
  - A sample with er=1 (carrier extend/false carrier) restarts the match.
  - Status holds during frames.

Decomposition:
- Package rgmii_pkg:
  - speed enum (SPEED_10, SPEED_100, SPEED_1000)
  - FSM state enum
  - inband_status_t struct {link, speed[1:0], duplex}
  - constant INBAND_STABLE_CYCLES=2
- One sub-module: rgmii_inband_status (sample compare, stability counter, status register).

Test Plan:
- 1000M, 64-byte frame 0x00..0x3F, er=0 -> 64 consecutive rx_valid pulses, bytes 0x00..0x3F, 1-cycle latency; frame_cnt=1, err_cnt=0.
- 100M, frame bytes 0xA5,0x5A sent as nibbles 5,A,A,5 on q1 -> rx_valid on alternate cycles, data 0xA5 then 0x5A; frame_cnt=1.
- 10M, 3 nibbles then dv=0 -> second byte emitted as 0x0N with rx_er=1; err_cnt=1.
- IFG with q1=q2=5'b0_1101 for 2 cycles -> link_up=1, link_speed=10, full_duplex=1. A single differing sample between identical ones -> no update.
- rst_n pulsed low mid-frame, released with dv=1 -> no rx_valid until dv=0 then a new frame; counters read 0 after reset.
- err_cnt preloaded to 0xFFFF by errored frames -> another errored frame leaves 0xFFFF. cnt_clr_i in the same cycle as a frame end -> both counters 0.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive sequencer.
package rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_e;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    FRAME     = 3'd2,
    NIB_LO    = 3'd3,
    NIB_HI    = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       link;
    logic [1:0] speed;
    logic       duplex;
  } inband_status_t;

  localparam int INBAND_STABLE_CYCLES = 2;

  // The reserved encoding 11 runs the byte path as gigabit.
  function automatic speed_e decode_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1000 : speed_e'(s);
  endfunction

  // In-band nibble on RXD is {duplex, speed[1:0], link}.
  function automatic inband_status_t nibble_to_status(input logic [3:0] n);
    inband_status_t st;
    st.link   = n[0];
    st.speed  = n[2:1];
    st.duplex = n[3];
    return st;
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band link status filter: a status nibble is accepted only after it has
// been seen on consecutive eligible inter-frame samples.
module rgmii_inband_status
  import rgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [3:0] sample,
  output logic       link,
  output logic [1:0] speed,
  output logic       duplex
);

  localparam logic [1:0] STABLE = 2'(INBAND_STABLE_CYCLES);

  inband_status_t cur;
  inband_status_t cand;
  inband_status_t stat;
  logic [1:0]     match_cnt;

  assign cur = nibble_to_status(sample);

  // Any cycle that is not a clean sample (frame, carrier extend, false
  // carrier) breaks the run of identical samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      stat      <= '0;
      match_cnt <= '0;
    end else if (!sample_en) begin
      match_cnt <= '0;
    end else if (match_cnt != 2'd0 && cur == cand) begin
      if (match_cnt != STABLE) match_cnt <= match_cnt + 2'd1;
      if (match_cnt >= STABLE - 2'd1) stat <= cur;
    end else begin
      cand      <= cur;
      match_cnt <= 2'd1;
    end
  end

  assign link   = stat.link;
  assign speed  = stat.speed;
  assign duplex = stat.duplex;

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive sequencer: turns DDR-captured {rx_ctl, rxd} samples into
// GMII-style bytes, tracks in-band status and keeps frame/error counters.
module rgmii_rx_ctrl
  import rgmii_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter bit INBAND_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           speed_i,
  input  logic                 cnt_clr_i,
  input  logic [4:0]           ddr_q1_i,
  input  logic [4:0]           ddr_q2_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_dv_o,
  output logic                 rx_er_o,
  output logic                 link_up_o,
  output logic [1:0]           link_speed_o,
  output logic                 full_duplex_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [2:0]           dbg_state_o
);

  rx_state_e state, state_d;
  speed_e    mode, mode_d, eff_mode;
  logic [3:0] lo_nib, lo_nib_d;
  logic       lo_er, lo_er_d;
  logic       frame_err, frame_err_d;
  logic [7:0] data_d;
  logic       valid_d, er_d, dv_d;
  logic       frame_end, frame_bad;
  logic       dv, er;

  assign dv = ddr_q1_i[4];
  assign er = ddr_q1_i[4] ^ ddr_q2_i[4];

  // speed_i is only honoured between frames.
  assign eff_mode = (state == IDLE) ? decode_speed(speed_i) : mode;

  always_comb begin
    state_d     = state;
    mode_d      = mode;
    lo_nib_d    = lo_nib;
    lo_er_d     = lo_er;
    frame_err_d = frame_err;
    data_d      = rx_data_o;
    valid_d     = 1'b0;
    er_d        = 1'b0;
    frame_end   = 1'b0;
    frame_bad   = frame_err;
    case (state)
      WAIT_IDLE: if (!dv) state_d = IDLE;
      IDLE: begin
        mode_d = eff_mode;
        if (dv) begin
          frame_err_d = er;
          if (eff_mode == SPEED_1000) begin
            data_d  = {ddr_q2_i[3:0], ddr_q1_i[3:0]};
            valid_d = 1'b1;
            er_d    = er;
            state_d = FRAME;
          end else begin
            lo_nib_d = ddr_q1_i[3:0];
            lo_er_d  = er;
            state_d  = NIB_HI;
          end
        end
      end
      FRAME: begin
        if (dv) begin
          data_d      = {ddr_q2_i[3:0], ddr_q1_i[3:0]};
          valid_d     = 1'b1;
          er_d        = er;
          frame_err_d = frame_err | er;
        end else begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
      NIB_HI: begin
        valid_d = 1'b1;
        if (dv) begin
          data_d      = {ddr_q1_i[3:0], lo_nib};
          er_d        = er | lo_er;
          frame_err_d = frame_err | er;
          state_d     = NIB_LO;
        end else begin
          // Odd nibble count: flush the stranded half byte as an error.
          data_d    = {4'h0, lo_nib};
          er_d      = 1'b1;
          frame_end = 1'b1;
          frame_bad = 1'b1;
          state_d   = IDLE;
        end
      end
      NIB_LO: begin
        if (dv) begin
          lo_nib_d    = ddr_q1_i[3:0];
          lo_er_d     = er;
          frame_err_d = frame_err | er;
          state_d     = NIB_HI;
        end else begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    // Frame-active spans every byte plus one trailing cycle.
    dv_d = valid_d | rx_valid_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_IDLE;
      mode       <= SPEED_10;
      lo_nib     <= '0;
      lo_er      <= 1'b0;
      frame_err  <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_er_o    <= 1'b0;
      rx_dv_o    <= 1'b0;
    end else begin
      state      <= state_d;
      mode       <= mode_d;
      lo_nib     <= lo_nib_d;
      lo_er      <= lo_er_d;
      frame_err  <= frame_err_d;
      rx_data_o  <= data_d;
      rx_valid_o <= valid_d;
      rx_er_o    <= er_d;
      rx_dv_o    <= dv_d;
    end
  end

  // Clear wins over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else if (cnt_clr_i) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else if (frame_end) begin
      if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (frame_bad && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  logic sample_en;
  assign sample_en = INBAND_EN && (state == IDLE) && !dv && !er;

  rgmii_inband_status u_inband (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .sample    (ddr_q1_i[3:0]),
    .link      (link_up_o),
    .speed     (link_speed_o),
    .duplex    (full_duplex_o)
  );

  assign dbg_state_o = state;

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Self-checking bench for rgmii_rx_ctrl: random and directed frames at all
// speeds, in-band status sequences, mid-frame reset, counter saturation/clear.
module tb_rgmii_rx_ctrl;

  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    speed;
  logic          cnt_clr;
  logic [4:0]    q1, q2;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_dv, rx_er;
  logic          link_up, full_duplex;
  logic [1:0]    link_speed;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic [2:0]    dbg_state;

  rgmii_rx_ctrl #(.CNT_WIDTH(CW), .INBAND_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .speed_i       (speed),
    .cnt_clr_i     (cnt_clr),
    .ddr_q1_i      (q1),
    .ddr_q2_i      (q2),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_dv_o       (rx_dv),
    .rx_er_o       (rx_er),
    .link_up_o     (link_up),
    .link_speed_o  (link_speed),
    .full_duplex_o (full_duplex),
    .frame_cnt_o   (frame_cnt),
    .err_cnt_o     (err_cnt),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state / reference model ----------------
  logic [8:0] exp_q[$];
  int         exp_t[$];
  logic [3:0] nib_src[$];
  logic [4:0] stat_src[$];
  logic [3:0] pool[3] = '{4'hD, 4'h3, 4'h6};
  int         checks = 0;
  int         errors = 0;
  int         m_frames, m_errs;
  logic [3:0] m_stat, m_prev;
  bit         m_prev_ok, had_frame, in_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every byte strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got er=%0b data=0x%0h, expected no byte (cycle %0d)",
                 rx_er, rx_data, cyc);
      end else begin
        check("rx_byte", {23'd0, rx_er, rx_data}, {23'd0, exp_q.pop_front()});
        check("rx_latency", cyc, exp_t.pop_front());
        check("rx_dv_with_valid", {31'd0, rx_dv}, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_frame(input bit bad);
    if (m_frames < MAXV) m_frames++;
    if (bad && m_errs < MAXV) m_errs++;
    had_frame = 1'b1;
    in_idle   = 1'b0;
  endtask

  task automatic model_sample(input logic [4:0] s);
    if (s[4]) m_prev_ok = 1'b0;
    else begin
      if (m_prev_ok && s[3:0] == m_prev) m_stat = s[3:0];
      m_prev    = s[3:0];
      m_prev_ok = 1'b1;
    end
  endtask

  task automatic check_status(input string name);
    check(name, {28'd0, full_duplex, link_speed, link_up}, {28'd0, m_stat});
  endtask

  task automatic frame_gig(input int n, input bit seq, input int er_pct, input bit chg);
    logic [7:0] b;
    logic       e;
    bit         bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      e = ($urandom_range(0, 99) < er_pct);
      exp_q.push_back({e, b});
      exp_t.push_back(cyc + 1);
      q1 = {1'b1, b[3:0]};
      q2 = {~e, b[7:4]};
      tick();
      bad |= e;
      if (chg) speed = 2'($urandom_range(0, 3));
    end
    count_frame(bad);
  endtask

  task automatic frame_nib(input int n, input int er_pct, input bit chg);
    logic [3:0] nib, lo;
    logic       e, lo_e;
    bit         bad;
    bad = 1'b0; lo = '0; lo_e = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (nib_src.size() > 0) nib = nib_src.pop_front();
      else nib = 4'($urandom);
      e = ($urandom_range(0, 99) < er_pct);
      if (j % 2 == 1) begin
        exp_q.push_back({lo_e | e, nib, lo});
        exp_t.push_back(cyc + 1);
      end else begin
        lo   = nib;
        lo_e = e;
      end
      q1 = {1'b1, nib};
      q2 = {~e, 4'($urandom)};
      tick();
      bad |= e;
      if (chg) speed = 2'($urandom_range(0, 3));
    end
    if (n % 2 == 1) begin
      exp_q.push_back({1'b1, 4'h0, lo});
      exp_t.push_back(cyc + 1);
      bad = 1'b1;
    end
    count_frame(bad);
  endtask

  // Inter-frame gap of n cycles; the first cycle carries the frame end.
  task automatic ifg(input int n, input bit clr, input logic [1:0] sp);
    logic [4:0] s;
    speed = sp; cnt_clr = clr; q1 = '0; q2 = '0;
    tick();
    cnt_clr = 1'b0;
    if (clr) begin m_frames = 0; m_errs = 0; end
    if (in_idle) model_sample(5'h00);
    else m_prev_ok = 1'b0;
    check("frame_cnt", {28'd0, frame_cnt}, m_frames);
    check("err_cnt", {28'd0, err_cnt}, m_errs);
    check_status("inband_status");
    if (had_frame) check("dv_tail", {31'd0, rx_dv}, 32'd1);
    for (int i = 1; i < n; i++) begin
      if (stat_src.size() > 0) s = stat_src.pop_front();
      else s = {($urandom_range(0, 7) == 0), pool[$urandom_range(0, 2)]};
      q1 = {1'b0, s[3:0]};
      q2 = {s[4], 4'($urandom)};
      tick();
      model_sample(s);
      check_status("inband_status");
      if (i == 2 && had_frame) check("dv_drop", {31'd0, rx_dv}, 32'd0);
    end
    had_frame = 1'b0;
    in_idle   = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0]  b;
    logic [1:0]  sp;
    rst_n = 1'b0; speed = 2'b10; cnt_clr = 1'b0; q1 = '0; q2 = '0;
    m_frames = 0; m_errs = 0; m_stat = '0; m_prev = '0;
    m_prev_ok = 1'b0; had_frame = 1'b0; in_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_counters", {24'd0, frame_cnt, err_cnt}, 32'd0);
    check("reset_status", {28'd0, full_duplex, link_speed, link_up}, 32'd0);
    rst_n = 1'b1;

    // 1000M 64-byte ramp, then 100M A5/5A, then 10M odd nibble count
    ifg(4, 1'b0, 2'b10);
    frame_gig(64, 1'b1, 0, 1'b0);
    ifg(4, 1'b0, 2'b01);
    check("gig_frame_cnt", {28'd0, frame_cnt}, 32'd1);
    nib_src = '{4'h5, 4'hA, 4'hA, 4'h5};
    frame_nib(4, 0, 1'b0);
    ifg(4, 1'b0, 2'b00);
    nib_src = '{4'h1, 4'h2, 4'h3};
    frame_nib(3, 0, 1'b0);
    ifg(3, 1'b0, 2'b10);
    check("odd_err_cnt", {28'd0, err_cnt}, 32'd1);

    // In-band: stable pair, interrupted patterns, er restart
    stat_src = '{5'h0D, 5'h0D};
    ifg(3, 1'b0, 2'b10);
    check("inband_link", {28'd0, full_duplex, link_speed, link_up}, 32'hD);
    stat_src = '{5'h03, 5'h05, 5'h03};
    ifg(4, 1'b0, 2'b10);
    stat_src = '{5'h03, 5'h13, 5'h03};
    ifg(4, 1'b0, 2'b10);
    check("inband_hold", {28'd0, full_duplex, link_speed, link_up}, 32'hD);

    // Reset mid-frame, released while dv is still high
    ifg(4, 1'b0, 2'b10);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back({1'b0, b});
      exp_t.push_back(cyc + 1);
      q1 = {1'b1, b[3:0]};
      q2 = {1'b1, b[7:4]};
      tick();
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_frames = 0; m_errs = 0; m_stat = '0; m_prev_ok = 1'b0;
    had_frame = 1'b0; in_idle = 1'b0;
    @(negedge clk);
    #2;
    check("midreset_counters", {24'd0, frame_cnt, err_cnt}, 32'd0);
    check("midreset_valid", {30'd0, rx_valid, rx_dv}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q1 = {1'b1, 4'($urandom)};
      q2 = {1'b1, 4'($urandom)};
      tick();
    end
    ifg(5, 1'b0, 2'b10);
    frame_gig(8, 1'b0, 0, 1'b0);
    ifg(4, 1'b0, 2'b01);

    // Random frames at random speeds with mid-frame speed changes
    for (int k = 0; k < 30; k++) begin
      sp = 2'($urandom_range(0, 3));
      ifg($urandom_range(3, 6), 1'b0, sp);
      if (sp[1]) frame_gig($urandom_range(1, 16), 1'b0, 10, 1'b1);
      else frame_nib($urandom_range(1, 21), 10, 1'b1);
    end

    // Drive the error counter into saturation
    for (int k = 0; k < MAXV + 2; k++) begin
      ifg(3, 1'b0, 2'b10);
      frame_gig(1, 1'b0, 100, 1'b0);
    end
    ifg(3, 1'b0, 2'b10);
    check("err_cnt_saturated", {28'd0, err_cnt}, MAXV);

    // Clear coinciding with a frame end
    frame_gig(2, 1'b0, 0, 1'b0);
    ifg(4, 1'b1, 2'b10);
    check("clr_at_frame_end", {24'd0, frame_cnt, err_cnt}, 32'd0);
    frame_gig(3, 1'b0, 0, 1'b0);
    ifg(4, 1'b0, 2'b10);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
